// File: rtl/cam_exposure_fsm.sv
// Camera capture sequencer: erase -> exposure of clamped length -> two-row readout.
// Optional CTRL_ABORT_EN adds an abort input that returns to IDLE from EXPOSE/READ.
module cam_exposure_fsm #(
  parameter int EX_W   = 5,
  parameter int EX_MIN = 2,
  parameter int EX_MAX = 30
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            init,
  input  logic [EX_W-1:0] ex_time,
`ifdef CTRL_ABORT_EN
  input  logic            abort,
`endif
  output logic            erase,
  output logic            expose,
  output logic            nre_1,
  output logic            nre_2,
  output logic            adc,
  output logic            busy
);

  localparam logic [EX_W-1:0] EX_LO  = EX_W'(EX_MIN);
  localparam logic [EX_W-1:0] EX_HI  = EX_W'(EX_MAX);
  localparam logic [EX_W-1:0] EX_ONE = EX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPOSE = 2'd1,
    S_READ   = 2'd2
  } state_t;

  function automatic logic [EX_W-1:0] clamp_ex(input logic [EX_W-1:0] v);
    if (v < EX_LO)      return EX_LO;
    else if (v > EX_HI) return EX_HI;
    else                return v;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [EX_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_step, w_step_nxt;
  logic            r_erase, r_expose, r_nre_1, r_nre_2, r_adc, r_busy;
  logic            w_erase, w_expose, w_nre_1, w_nre_2, w_adc, w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = r_step;
    case (r_state)
      S_IDLE: begin
        if (init) begin
          w_state_nxt = S_EXPOSE;
          w_cnt_nxt   = clamp_ex(ex_time) - EX_ONE;
          w_step_nxt  = 3'd0;
        end
      end
      S_EXPOSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_READ;
          w_step_nxt  = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - EX_ONE;
        end
      end
      S_READ: begin
        if (r_step == 3'd7) w_state_nxt = S_IDLE;
        else                w_step_nxt  = r_step + 3'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef CTRL_ABORT_EN
    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
`endif
  end

  // Outputs are decoded from the next state so the registered lines change on the same edge as the state.
  always_comb begin
    w_erase  = (w_state_nxt == S_IDLE);
    w_expose = (w_state_nxt == S_EXPOSE);
    w_busy   = (w_state_nxt != S_IDLE);
    w_nre_1  = 1'b1;
    w_nre_2  = 1'b1;
    w_adc    = 1'b0;
    if (w_state_nxt == S_READ) begin
      w_nre_1 = !(w_step_nxt <= 3'd2);
      w_nre_2 = !((w_step_nxt >= 3'd4) && (w_step_nxt <= 3'd6));
      w_adc   = (w_step_nxt == 3'd1) || (w_step_nxt == 3'd5);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_step   <= 3'd0;
      r_erase  <= 1'b1;
      r_expose <= 1'b0;
      r_nre_1  <= 1'b1;
      r_nre_2  <= 1'b1;
      r_adc    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_step   <= w_step_nxt;
      r_erase  <= w_erase;
      r_expose <= w_expose;
      r_nre_1  <= w_nre_1;
      r_nre_2  <= w_nre_2;
      r_adc    <= w_adc;
      r_busy   <= w_busy;
    end
  end

  assign erase  = r_erase;
  assign expose = r_expose;
  assign nre_1  = r_nre_1;
  assign nre_2  = r_nre_2;
  assign adc    = r_adc;
  assign busy   = r_busy;

endmodule
